// File: rtl/pipeline_mem_access_stage.sv
// Memory-access stage: issues loads/stores on a req/ready data port, formats load data,
// stalls upstream and bubbles downstream while an access is outstanding.
module pipeline_mem_access_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rd_write_address_in,
    input  logic        rd_select_in,
    input  logic        rd_write_enable_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_en,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [4:0]  rd_write_address_out,
    output logic        rd_select_out,
    output logic        rd_write_enable_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] dmem_data_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  rd_addr_q;
    logic        rd_sel_q, rd_we_q, we_q, uns_q;
    logic [31:0] alu_q, wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  ben_q;
    logic        latch_en;

    logic        is_store, is_load, is_mem, misaligned;
    logic [3:0]  in_ben;
    logic [31:0] in_wdata;

    logic        req_c, we_c, stall_c, rd_sel_c, rd_we_c, mis_c, berr_c;
    logic [31:0] addr_c, wdata_c, alu_c, data_c;
    logic [3:0]  ben_c;
    logic [4:0]  rd_addr_c;

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   fmt_load = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   fmt_load = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    // Store wins when both read and write are asserted.
    assign is_store = mem_write_in;
    assign is_load  = mem_read_in & ~mem_write_in;
    assign is_mem   = is_store | is_load;

    always_comb begin
        misaligned = 1'b0;
        in_ben     = 4'b0000;
        in_wdata   = store_data_in;
        case (mem_size_in)
            2'b00: begin
                in_ben   = 4'b0001 << alu_result_in[1:0];
                in_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                misaligned = alu_result_in[0];
                in_ben     = 4'b0011 << alu_result_in[1:0];
                in_wdata   = {2{store_data_in[15:0]}};
            end
            2'b10: begin
                misaligned = |alu_result_in[1:0];
                in_ben     = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
        if (!is_store) in_ben = 4'b0000;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = '0;
        wdata_c   = '0;
        ben_c     = '0;
        stall_c   = 1'b0;
        rd_addr_c = rd_write_address_in;
        rd_sel_c  = rd_select_in;
        rd_we_c   = rd_write_enable_in;
        alu_c     = alu_result_in;
        data_c    = '0;
        mis_c     = 1'b0;
        berr_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mem && misaligned) begin
                    mis_c   = 1'b1;
                    rd_we_c = 1'b0;
                end else if (is_mem) begin
                    req_c   = 1'b1;
                    we_c    = is_store;
                    addr_c  = {alu_result_in[31:2], 2'b00};
                    wdata_c = in_wdata;
                    ben_c   = in_ben;
                    if (dmem_ready) begin
                        if (is_load)
                            data_c = fmt_load(dmem_rdata, mem_size_in, mem_unsigned_in,
                                              alu_result_in[1:0]);
                    end else begin
                        stall_c  = 1'b1;
                        rd_we_c  = 1'b0;
                        latch_en = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_WAIT;
                    end
                end
            end
            default: begin
                req_c     = 1'b1;
                we_c      = we_q;
                addr_c    = {alu_q[31:2], 2'b00};
                wdata_c   = wdata_q;
                ben_c     = ben_q;
                rd_addr_c = rd_addr_q;
                rd_sel_c  = rd_sel_q;
                rd_we_c   = rd_we_q;
                alu_c     = alu_q;
                if (dmem_ready) begin
                    if (!we_q) data_c = fmt_load(dmem_rdata, size_q, uns_q, alu_q[1:0]);
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    // Timed-out access is dropped: no writeback, pipeline released.
                    berr_c  = 1'b1;
                    rd_we_c = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    rd_we_c = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_addr_q <= '0;
            rd_sel_q  <= 1'b0;
            rd_we_q   <= 1'b0;
            alu_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            ben_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                rd_addr_q <= rd_write_address_in;
                rd_sel_q  <= rd_select_in;
                rd_we_q   <= rd_write_enable_in;
                alu_q     <= alu_result_in;
                size_q    <= mem_size_in;
                uns_q     <= mem_unsigned_in;
                we_q      <= is_store;
                wdata_q   <= in_wdata;
                ben_q     <= in_ben;
            end
        end
    end

    // Everything is forced low while reset is held, including an abandoned request.
    assign dmem_req             = reset & req_c;
    assign dmem_we              = reset & we_c;
    assign dmem_addr            = reset ? addr_c : '0;
    assign dmem_wdata           = reset ? wdata_c : '0;
    assign dmem_byte_en         = reset ? ben_c : '0;
    assign stall_out            = reset & stall_c;
    assign rd_write_address_out = reset ? rd_addr_c : '0;
    assign rd_select_out        = reset & rd_sel_c;
    assign rd_write_enable_out  = reset & rd_we_c;
    assign alu_result_out       = reset ? alu_c : '0;
    assign dmem_data_out        = reset ? data_c : '0;
    assign misaligned_out       = reset & mis_c;
    assign bus_error_out        = reset & berr_c;
endmodule
